// File: rtl/bus_matrix_rr_arbiter.sv
// Packet-locked round-robin arbiter sharing one valid/ready/last slave port among
// N_MASTERS upstream masters. A grant is held from the first beat through the last beat.

module bus_matrix_rr_arbiter_chk #(
   parameter int N_MASTERS = 4
) (
   input logic                 clk,
   input logic                 rst,
   input logic [N_MASTERS-1:0] grant,
   input logic                 busy,
   input logic [N_MASTERS-1:0] req_ready,
   input logic                 valid
);

   a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
   a_busy_matches_grant: assert property (@(posedge clk) disable iff (rst) busy == (|grant));
   a_ready_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
   a_ready_only_busy: assert property (@(posedge clk) disable iff (rst) (|req_ready) |-> busy);
   a_valid_only_busy: assert property (@(posedge clk) disable iff (rst) valid |-> busy);

endmodule

module bus_matrix_rr_arbiter #(
   parameter int N_MASTERS = 4,
   parameter int WIDTH     = 32,
   parameter int IDX_W     = $clog2(N_MASTERS)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_MASTERS*WIDTH-1:0] req_data_i,
   input  logic [N_MASTERS-1:0]       req_valid_i,
   input  logic [N_MASTERS-1:0]       req_last_i,
   output logic [N_MASTERS-1:0]       req_ready_o,
   output logic [WIDTH-1:0]           data_o,
   output logic                       valid_o,
   output logic                       last_o,
   input  logic                       ready_i,
   output logic [N_MASTERS-1:0]       grant_o,
   output logic [IDX_W-1:0]           grant_idx_o,
   output logic                       busy_o
);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t                 state_r;
   state_t                 state_nxt_s;
   logic [N_MASTERS-1:0]   grant_r;
   logic [N_MASTERS-1:0]   grant_nxt_s;
   logic [IDX_W-1:0]       grant_idx_r;
   logic [IDX_W-1:0]       grant_idx_nxt_s;
   logic [IDX_W-1:0]       rr_ptr_r;
   logic [IDX_W-1:0]       rr_ptr_nxt_s;
   logic [IDX_W-1:0]       rr_ptr_inc_s;
   logic [IDX_W:0]         grant_idx_inc_s;
   logic [IDX_W-1:0]       winner_s;
   logic                   any_req_s;
   logic                   xfer_last_s;
   logic [WIDTH-1:0]       data_sel_s;

   // First requesting master at or above ptr, wrapping modulo N_MASTERS.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [N_MASTERS-1:0] req,
                                                input logic [IDX_W-1:0]     ptr);
      logic [IDX_W-1:0] pick;
      logic             found;
      logic [IDX_W:0]   cand;
      pick  = ptr;
      found = 1'b0;
      for (int k = 0; k < N_MASTERS; k++) begin
         cand = {1'b0, ptr} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(N_MASTERS)) begin
            cand = cand - (IDX_W+1)'(N_MASTERS);
         end else begin
            cand = cand;
         end
         if (!found && req[cand[IDX_W-1:0]]) begin
            pick  = cand[IDX_W-1:0];
            found = 1'b1;
         end else begin
            found = found;
         end
      end
      return pick;
   endfunction

   assign any_req_s = |req_valid_i;
   assign winner_s  = rr_pick(req_valid_i, rr_ptr_r);

   // Owner index plus one, wrapped so the pointer never reaches N_MASTERS.
   always_comb begin
      grant_idx_inc_s = {1'b0, grant_idx_r} + {{IDX_W{1'b0}}, 1'b1};
      if (grant_idx_inc_s == (IDX_W+1)'(N_MASTERS)) begin
         rr_ptr_inc_s = {IDX_W{1'b0}};
      end else begin
         rr_ptr_inc_s = grant_idx_inc_s[IDX_W-1:0];
      end
   end

   // One-hot AND-OR select of the owner's payload.
   always_comb begin
      data_sel_s = {WIDTH{1'b0}};
      for (int m = 0; m < N_MASTERS; m++) begin
         data_sel_s = data_sel_s | (req_data_i[m*WIDTH +: WIDTH] & {WIDTH{grant_r[m]}});
      end
   end

   // Forwarding path: combinational from the registered grant, silent when idle.
   always_comb begin
      valid_o     = 1'b0;
      last_o      = 1'b0;
      data_o      = {WIDTH{1'b0}};
      req_ready_o = {N_MASTERS{1'b0}};
      if (state_r == LOCKED) begin
         valid_o     = |(req_valid_i & grant_r);
         last_o      = |(req_last_i & grant_r);
         data_o      = data_sel_s;
         req_ready_o = grant_r & {N_MASTERS{ready_i}};
      end else begin
         valid_o     = 1'b0;
         last_o      = 1'b0;
         data_o      = {WIDTH{1'b0}};
         req_ready_o = {N_MASTERS{1'b0}};
      end
   end

   assign xfer_last_s = valid_o && ready_i && last_o;

   // Next-state: arbitrate in IDLE, hold the lock until the last beat transfers.
   always_comb begin
      state_nxt_s     = state_r;
      grant_nxt_s     = grant_r;
      grant_idx_nxt_s = grant_idx_r;
      rr_ptr_nxt_s    = rr_ptr_r;
      case (state_r)
         IDLE: begin
            if (any_req_s) begin
               state_nxt_s     = LOCKED;
               grant_nxt_s     = {{(N_MASTERS-1){1'b0}}, 1'b1} << winner_s;
               grant_idx_nxt_s = winner_s;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         LOCKED: begin
            if (xfer_last_s) begin
               state_nxt_s  = IDLE;
               grant_nxt_s  = {N_MASTERS{1'b0}};
               rr_ptr_nxt_s = rr_ptr_inc_s;
            end else begin
               state_nxt_s = LOCKED;
            end
         end
         default: begin
            state_nxt_s  = IDLE;
            grant_nxt_s  = {N_MASTERS{1'b0}};
            rr_ptr_nxt_s = {IDX_W{1'b0}};
         end
      endcase
   end

   // State, grant and priority pointer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         grant_r     <= {N_MASTERS{1'b0}};
         grant_idx_r <= {IDX_W{1'b0}};
         rr_ptr_r    <= {IDX_W{1'b0}};
      end else begin
         state_r     <= state_nxt_s;
         grant_r     <= grant_nxt_s;
         grant_idx_r <= grant_idx_nxt_s;
         rr_ptr_r    <= rr_ptr_nxt_s;
      end
   end

   assign grant_o     = grant_r;
   assign grant_idx_o = grant_idx_r;
   assign busy_o      = (state_r == LOCKED);

   bus_matrix_rr_arbiter_chk #(
      .N_MASTERS (N_MASTERS)
   ) u_chk (
      .clk       (clk),
      .rst       (rst),
      .grant     (grant_o),
      .busy      (busy_o),
      .req_ready (req_ready_o),
      .valid     (valid_o)
   );

endmodule
